// File: rtl/serial_alu_ctrl.sv
// serial_alu_ctrl -- bit-serial ALU controller around a single alu1bit slice.
//
// Latches two N-bit operands and an op code on an accepted start, then streams
// the operands LSB first through one alu1bit slice, one bit per clock. The
// carry is held in a register between bits, and the sum bits are shifted into
// an N-bit result.
//
// Optional build macro: SERIAL_ALU_OVF_EN adds the signed-overflow output ovf.
//
// alu1bit ports:
//   a, b    in   operand bits
//   cin     in   carry in
//   op      in   00 NOR, 01 XOR, 10 ADD, 11 SUB (a inverted)
//   s       out  result bit
//   cout    out  carry out (0 for logic ops)
//
// serial_alu_ctrl ports:
//   clk     in   system clock, rising edge
//   rst     in   asynchronous active-high reset
//   start   in   request, sampled only in IDLE
//   op      in   00 NOR, 01 XOR, 10 ADD, 11 SUB (B - A)
//   a, b    in   N-bit operands, latched on an accepted start
//   busy    out  high while the operation is running
//   done    out  one-cycle pulse when result is valid
//   result  out  completed result, held until the next completion
//   cout    out  final carry for arithmetic ops, 0 for logic ops
//   ovf     out  (SERIAL_ALU_OVF_EN only) signed overflow for arithmetic ops

module alu1bit (
    input  logic       a,
    input  logic       b,
    input  logic       cin,
    input  logic [1:0] op,
    output logic       s,
    output logic       cout
);
    logic ai;

    always_comb begin
        ai   = a ^ op[0];   // SUB inverts a; with cin seeded to 1 this gives b - a
        s    = 1'b0;
        cout = 1'b0;
        unique case (op)
            2'b00: s = ~(a | b);
            2'b01: s = a ^ b;
            default: begin
                s    = ai ^ b ^ cin;
                cout = (ai & b) | (ai & cin) | (b & cin);
            end
        endcase
    end
endmodule

module serial_alu_ctrl #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result,
    output logic         cout
`ifdef SERIAL_ALU_OVF_EN
    ,
    output logic         ovf
`endif
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [N-1:0]  a_sh;
    logic [N-1:0]  b_sh;
    logic [N-1:0]  res_sh;
    logic [1:0]    op_q;
    logic          carry_q;
    logic [CW-1:0] cnt;

    logic          alu_s;
    logic          alu_cout;
    logic          last_bit;

    alu1bit u_alu (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry_q),
        .op   (op_q),
        .s    (alu_s),
        .cout (alu_cout)
    );

    assign last_bit = (cnt == CW'(N - 1));

`ifdef SERIAL_ALU_OVF_EN
    // Carry into the MSB slice, captured while that slice is being evaluated.
    logic cin_msb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cin_msb <= 1'b0;
        end else if (state == RUN && last_bit) begin
            cin_msb <= carry_q;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            cout    <= 1'b0;
            a_sh    <= '0;
            b_sh    <= '0;
            res_sh  <= '0;
            op_q    <= 2'b00;
            carry_q <= 1'b0;
            cnt     <= '0;
`ifdef SERIAL_ALU_OVF_EN
            ovf     <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh    <= a;
                        b_sh    <= b;
                        op_q    <= op;
                        carry_q <= (op == 2'b11);
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    a_sh    <= a_sh >> 1;
                    b_sh    <= b_sh >> 1;
                    res_sh  <= {alu_s, res_sh[N-1:1]};
                    carry_q <= op_q[1] ? alu_cout : 1'b0;
                    cnt     <= cnt + 1'b1;
                    if (last_bit) begin
                        // Final bit goes straight into result alongside the shift.
                        result <= {alu_s, res_sh[N-1:1]};
                        cout   <= op_q[1] ? alu_cout : 1'b0;
`ifdef SERIAL_ALU_OVF_EN
                        // carry_q is the MSB carry-in this cycle; cin_msb holds it afterwards.
                        ovf    <= op_q[1] ? (carry_q ^ alu_cout) : 1'b0;
`endif
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_alu_ctrl.sv
// tb_serial_alu_ctrl -- self-checking bench for serial_alu_ctrl (N = 8).
// Directed cases plus randomized operations against an arithmetic reference
// model. Honours SERIAL_ALU_OVF_EN when the design is built with it.
`timescale 1ns/1ps

module tb_serial_alu_ctrl;
    localparam int N = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [1:0]   op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         busy;
    logic         done;
    logic [N-1:0] result;
    logic         cout;
`ifdef SERIAL_ALU_OVF_EN
    logic         ovf;
`endif

    int tests;
    int fails;

    serial_alu_ctrl #(.N(N)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout)
`ifdef SERIAL_ALU_OVF_EN
        ,
        .ovf    (ovf)
`endif
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    task automatic chk(input string tag, input longint obs, input longint exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    task automatic model(input logic [1:0] mop, input logic [N-1:0] ma, input logic [N-1:0] mb,
                         output logic [N-1:0] r, output logic c, output logic v);
        longint ua, ub, sa, sb, full, sres;
        ua = longint'(ma);
        ub = longint'(mb);
        sa = (ua >= (64'sd1 <<< (N - 1))) ? ua - (64'sd1 <<< N) : ua;
        sb = (ub >= (64'sd1 <<< (N - 1))) ? ub - (64'sd1 <<< N) : ub;
        c = 1'b0;
        v = 1'b0;
        case (mop)
            2'b00: r = ~(ma | mb);
            2'b01: r = ma ^ mb;
            2'b10: begin
                full = ua + ub;
                r    = N'(full);
                c    = (full >= (64'sd1 <<< N));
                sres = sa + sb;
                v    = (sres > (64'sd1 <<< (N - 1)) - 1) || (sres < -(64'sd1 <<< (N - 1)));
            end
            default: begin
                full = ub - ua;
                r    = N'(full);
                c    = (ub >= ua);
                sres = sb - sa;
                v    = (sres > (64'sd1 <<< (N - 1)) - 1) || (sres < -(64'sd1 <<< (N - 1)));
            end
        endcase
    endtask

    // Issue one operation, scramble inputs after acceptance, check timing and results.
    task automatic run_op(input string tag, input logic [1:0] top, input logic [N-1:0] ta,
                          input logic [N-1:0] tb);
        logic [N-1:0] er;
        logic ec, ev;
        int busy_cnt, done_at;
        model(top, ta, tb, er, ec, ev);
        @(negedge clk);
        op = top; a = ta; b = tb; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = N'($urandom); b = N'($urandom); op = 2'($urandom);
        chk({tag, "_busy0"}, longint'(busy), 1);
        busy_cnt = 1;
        done_at  = -1;
        for (int i = 1; i < N + 4 && done_at < 0; i++) begin
            @(negedge clk);
            if (done) done_at = i;
            else if (busy) busy_cnt++;
        end
        chk({tag, "_busylen"}, longint'(busy_cnt), N);
        chk({tag, "_doneat"}, longint'(done_at), N);
        chk({tag, "_busyatdone"}, longint'(busy), 0);
        chk({tag, "_result"}, longint'(result), longint'(er));
        chk({tag, "_cout"}, longint'(cout), longint'(ec));
`ifdef SERIAL_ALU_OVF_EN
        chk({tag, "_ovf"}, longint'(ovf), longint'(ev));
`endif
        @(negedge clk);
        chk({tag, "_donepulse"}, longint'(done), 0);
        chk({tag, "_hold"}, longint'(result), longint'(er));
    endtask

    initial begin
        int dcount;
        tests = 0;
        fails = 0;
        rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
        #120;
        chk("rst_busy", longint'(busy), 0);
        chk("rst_done", longint'(done), 0);
        chk("rst_result", longint'(result), 0);
        chk("rst_cout", longint'(cout), 0);
`ifdef SERIAL_ALU_OVF_EN
        chk("rst_ovf", longint'(ovf), 0);
`endif
        @(negedge clk);
        rst = 1'b0;

        run_op("add1", 2'b10, 8'h0F, 8'h3C);
        run_op("add2", 2'b10, 8'hFF, 8'h01);
        run_op("add3", 2'b10, 8'h7F, 8'h01);
        run_op("sub1", 2'b11, 8'h05, 8'h12);
        run_op("sub2", 2'b11, 8'h12, 8'h05);
        run_op("nor1", 2'b00, 8'hF0, 8'h0C);
        run_op("xor1", 2'b01, 8'hAA, 8'h0F);
        run_op("sub0", 2'b11, 8'h00, 8'h00);

        // start during RUN must be ignored
        @(negedge clk);
        op = 2'b10; a = 8'h01; b = 8'h01; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        op = 2'b01; a = 8'hC3; b = 8'h5A; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dcount = 0;
        for (int i = 0; i < N + 6; i++) begin
            @(negedge clk);
            if (done) dcount++;
        end
        chk("ign_donecnt", longint'(dcount), 1);
        chk("ign_result", longint'(result), 8'h02);
        chk("ign_busy", longint'(busy), 0);

        // reset mid-RUN
        @(negedge clk);
        op = 2'b10; a = 8'h33; b = 8'h44; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #10 rst = 1'b1;
        #1;
        chk("mrst_busy", longint'(busy), 0);
        chk("mrst_done", longint'(done), 0);
        chk("mrst_result", longint'(result), 0);
        chk("mrst_cout", longint'(cout), 0);
        #39 rst = 1'b0;
        dcount = 0;
        for (int i = 0; i < N + 4; i++) begin
            @(negedge clk);
            if (done || busy) dcount++;
        end
        chk("mrst_quiet", longint'(dcount), 0);
        run_op("post_rst", 2'b10, 8'h10, 8'h20);

        // randomized operations
        for (int i = 0; i < 40; i++) begin
            run_op("rnd", 2'($urandom), N'($urandom), N'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end
endmodule
